score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Game-side score keeper upstream of the on-screen score renderer.
//  Counts food-eaten events during play and drives the 7-bit score bus (0..99), stepping it by exactly +1 per event.
//  Also keeps a session high score, a new-record flag and a speed level for the snake mover.
//  Game-phase FSM: IDLE / PLAY / OVER.
// PARAMETERS
//  SCORE_W     7   width of score and high_score
//  SCORE_MAX   99  saturation value of score; equals the 2-digit display limit
//  LEVEL_STEP  10  points per level increment
//  LEVEL_W     4   width of level
//  LEVEL_MAX   9   saturation value of level
// PORTS
//  clock_25     in   1        system pixel clock; all logic on rising edge
//  reset        in   1        asynchronous, active-high; full clear
//  sync_reset   in   1        synchronous, active-high; new-game clear, keeps high_score
//  start        in   1        1-cycle pulse from the game controller: begin a game
//  food_eaten   in   1        level from the collision logic; may stay high several cycles
//  game_over    in   1        level or pulse from the collision logic
//  score        out  SCORE_W  current score, monotonic +1 steps while in PLAY
//  high_score   out  SCORE_W  best final score since reset
//  new_record   out  1        last finished game set a new high_score
//  level        out  LEVEL_W  score/LEVEL_STEP, saturating at LEVEL_MAX
//  level_up     out  1        1-cycle pulse when level increments
//  playing      out  1        FSM in PLAY
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset values (reset): state=IDLE; score, high_score, level, step_cnt = 0.
//    Also cleared: new_record, level_up, playing, food_d.
//  Priority: reset > sync_reset > FSM.
//  sync_reset: same clear as reset, except high_score is held.
//  Edge detect: food_d <= food_eaten every cycle. eat = food_eaten & ~food_d & (state==PLAY).
//    One point per rising edge of food_eaten.
//  Event latency: score, step_cnt and level update on the edge where eat=1.
//    The new score is visible the cycle after food_eaten first reads 1.
//  Score: eat with score<SCORE_MAX -> score+1. At SCORE_MAX eat is dropped: no score or level change, no level_up.
//  Level: step_cnt counts 0..LEVEL_STEP-1 on accepted eats.
//    Accepted eat at step_cnt==LEVEL_STEP-1: step_cnt <= 0.
//    In that case, if level<LEVEL_MAX: level+1 and level_up=1 for exactly one cycle.
//    At LEVEL_MAX, level holds and there is no pulse.
//  FSM:
//    IDLE --start--> PLAY: clear score, level, step_cnt, new_record.
//    PLAY --game_over--> OVER.
//    OVER --start--> PLAY: same clears as IDLE->PLAY.
//    Ignored: start in PLAY; game_over in IDLE or OVER; food_eaten outside PLAY (food_d still tracks).
//  High score: on the PLAY->OVER transition, with final = score_next (includes a same-cycle eat):
//    if final > high_score: high_score <= final and new_record <= 1. Otherwise new_record <= 0.
//  Simultaneous eat + game_over in PLAY: the point counts and is included in the high-score compare.
//  Simultaneous start + sync_reset: sync_reset wins; FSM ends in IDLE.
//  Downstream contract: the renderer tracks digits incrementally.
//    score never decreases without sync_reset; top level pulses sync_reset with start.
//  Reset mid-play: all outputs at reset values on the next observable edge.
// STRUCTURE
//  score_defs.vh: state encodings (S_IDLE=2'd0, S_PLAY=2'd1, S_OVER=2'd2), SCORE_MAX, LEVEL_STEP.
//    Shared with the game controller.
//  Sub-module rise_detect (clk, rst, sync_clr, in, en, pulse): food_eaten edge detector, reusable for buttons.
//  Remaining logic: FSM plus score/level/high-score registers, one always block per register group.
// TESTING
//  1 reset; start; 3 food_eaten pulses, 1 cycle each -> score=3, level=0, playing=1.
//  2 food_eaten held high 20 cycles in PLAY -> score +1 only; a second rising edge adds 1 more.
//  3 10 eats from 0 -> score=10, level=1, one level_up pulse on the 10th update cycle.
//    Eats to 99, then 2 more -> score stays 99, level=9, no extra level_up.
//  4 game 1 ends at 12 -> high_score=12, new_record=1.
//    game 2 ends at 7 -> high_score=12, new_record=0.
//    game 3 eat+game_over same cycle at 12 -> final 13, high_score=13, new_record=1.
//  5 sync_reset mid-play at score 25 -> score=0, state IDLE, high_score unchanged.
//    reset -> high_score=0.
//  6 food_eaten and game_over pulsed in IDLE/OVER, start in PLAY -> no score or state change.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// Shared game-phase encodings and score/level limits for the score keeper.
package score_tracker_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam int SCORE_W    = 7;
   localparam int SCORE_MAX  = 99;
   localparam int LEVEL_STEP = 10;
   localparam int LEVEL_W    = 4;
   localparam int LEVEL_MAX  = 9;
   localparam int STEP_W     = 4;

endpackage

// File: rtl/score_tracker_rise_detect.sv
// Rising-edge detector with enable; reusable for the food strobe and buttons.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic sync_clr,
   input  logic in,
   input  logic en,
   output logic pulse
);

   logic in_d;

   // Delayed copy of the input; tracks every cycle regardless of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           in_d <= 1'b0;
      else if (sync_clr) in_d <= 1'b0;
      else               in_d <= in;
   end

   assign pulse = in & ~in_d & en;

endmodule

// File: rtl/score_tracker.sv
// Score keeper: game-phase FSM, +1 score per food edge, level, session high score.
module score_tracker
   import score_tracker_pkg::*;
#(
   parameter int SCORE_W_P    = SCORE_W,
   parameter int SCORE_MAX_P  = SCORE_MAX,
   parameter int LEVEL_STEP_P = LEVEL_STEP,
   parameter int LEVEL_W_P    = LEVEL_W,
   parameter int LEVEL_MAX_P  = LEVEL_MAX
) (
   input  logic                 clock_25,
   input  logic                 reset,
   input  logic                 sync_reset,
   input  logic                 start,
   input  logic                 food_eaten,
   input  logic                 game_over,
   output logic [SCORE_W_P-1:0] score,
   output logic [SCORE_W_P-1:0] high_score,
   output logic                 new_record,
   output logic [LEVEL_W_P-1:0] level,
   output logic                 level_up,
   output logic                 playing
);

   localparam logic [SCORE_W_P-1:0] SCORE_LIM = SCORE_W_P'(SCORE_MAX_P);
   localparam logic [LEVEL_W_P-1:0] LEVEL_LIM = LEVEL_W_P'(LEVEL_MAX_P);
   localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(LEVEL_STEP_P - 1);

   state_t               state, state_next;
   logic                 eat, accept, wrap, bump;
   logic                 start_game, end_game;
   logic [STEP_W-1:0]    step_cnt;
   logic [SCORE_W_P-1:0] score_next;

   rise_detect u_food_edge (
      .clk      (clock_25),
      .rst      (reset),
      .sync_clr (sync_reset),
      .in       (food_eaten),
      .en       (state == S_PLAY),
      .pulse    (eat)
   );

   // Points stop at the display limit; a dropped eat touches nothing.
   assign accept     = eat && (score < SCORE_LIM);
   assign wrap       = accept && (step_cnt == STEP_LAST);
   assign bump       = wrap && (level < LEVEL_LIM);
   assign score_next = accept ? score + 1'b1 : score;
   assign playing    = (state == S_PLAY);

   // Next-state logic; start only acts outside PLAY, game_over only inside it.
   always_comb begin
      state_next = state;
      start_game = 1'b0;
      end_game   = 1'b0;
      case (state)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_next = S_PLAY;
               start_game = 1'b1;
            end
         end
         S_PLAY: begin
            if (game_over) begin
               state_next = S_OVER;
               end_game   = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Phase register; sync_reset overrides any same-cycle start.
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset)           state <= S_IDLE;
      else if (sync_reset) state <= S_IDLE;
      else                 state <= state_next;
   end

   // Score, level progress and the one-cycle level_up strobe.
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         score    <= '0;
         step_cnt <= '0;
         level    <= '0;
         level_up <= 1'b0;
      end else if (sync_reset) begin
         score    <= '0;
         step_cnt <= '0;
         level    <= '0;
         level_up <= 1'b0;
      end else begin
         level_up <= 1'b0;
         if (start_game) begin
            score    <= '0;
            step_cnt <= '0;
            level    <= '0;
         end else if (accept) begin
            score    <= score_next;
            step_cnt <= wrap ? '0 : step_cnt + 1'b1;
            if (bump) begin
               level    <= level + 1'b1;
               level_up <= 1'b1;
            end
         end
      end
   end

   // Session best; compared against score_next so a final-cycle eat counts.
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         high_score <= '0;
         new_record <= 1'b0;
      end else if (sync_reset) begin
         new_record <= 1'b0;
      end else if (start_game) begin
         new_record <= 1'b0;
      end else if (end_game) begin
         if (score_next > high_score) begin
            high_score <= score_next;
            new_record <= 1'b1;
         end else begin
            new_record <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with a cycle-level reference model and scoreboard queue.
module tb_score_tracker;

   logic       clock_25 = 1'b0;
   logic       reset, sync_reset, start, food_eaten, game_over;
   logic [6:0] score, high_score;
   logic       new_record, level_up, playing;
   logic [3:0] level;

   score_tracker dut (
      .clock_25   (clock_25),
      .reset      (reset),
      .sync_reset (sync_reset),
      .start      (start),
      .food_eaten (food_eaten),
      .game_over  (game_over),
      .score      (score),
      .high_score (high_score),
      .new_record (new_record),
      .level      (level),
      .level_up   (level_up),
      .playing    (playing)
   );

   always #20 clock_25 = ~clock_25;

   typedef struct {
      logic [6:0] score;
      logic [6:0] hs;
      logic [3:0] level;
      logic       lu;
      logic       pl;
      logic       nr;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   lu_count = 0;

   // reference model state
   int   m_state, m_score, m_hs, m_level, m_step;
   logic m_nr, m_lu, m_fd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      assert (act === expv) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, act, expv);
      end
   endtask

   task automatic model_clear();
      m_state = 0; m_score = 0; m_hs = 0; m_level = 0; m_step = 0;
      m_nr = 0; m_lu = 0; m_fd = 0;
   endtask

   // One clock: drive inputs, advance model, push expectation, pop after edge.
   task automatic step(input logic st, input logic fe, input logic go, input logic sr);
      bit eat, acc;
      int nsc;
      exp_t e, g;
      start = st; food_eaten = fe; game_over = go; sync_reset = sr;
      eat = fe && !m_fd && (m_state == 1);
      acc = eat && (m_score < 99);
      if (sr) begin
         m_state = 0; m_score = 0; m_level = 0; m_step = 0;
         m_nr = 0; m_lu = 0; m_fd = 0;
      end else begin
         m_lu = 0;
         nsc = acc ? m_score + 1 : m_score;
         if (m_state == 1) begin
            if (acc) begin
               m_score = nsc;
               if (m_step == 9) begin
                  m_step = 0;
                  if (m_level < 9) begin
                     m_level++;
                     m_lu = 1;
                  end
               end else begin
                  m_step++;
               end
            end
            if (go) begin
               m_state = 2;
               if (nsc > m_hs) begin
                  m_hs = nsc;
                  m_nr = 1;
               end else begin
                  m_nr = 0;
               end
            end
         end else if (st) begin
            m_state = 1; m_score = 0; m_level = 0; m_step = 0; m_nr = 0;
         end
         m_fd = fe;
      end
      e.score = 7'(m_score); e.hs = 7'(m_hs); e.level = 4'(m_level);
      e.lu = m_lu; e.pl = (m_state == 1); e.nr = m_nr;
      exp_q.push_back(e);
      @(posedge clock_25);
      #1;
      g = exp_q.pop_front();
      chk("score", 32'(score), 32'(g.score));
      chk("high_score", 32'(high_score), 32'(g.hs));
      chk("level", 32'(level), 32'(g.level));
      chk("level_up", 32'(level_up), 32'(g.lu));
      chk("playing", 32'(playing), 32'(g.pl));
      chk("new_record", 32'(new_record), 32'(g.nr));
      if (level_up === 1'b1) lu_count++;
   endtask

   task automatic eat_n(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      start = 0; food_eaten = 0; game_over = 0; sync_reset = 0;
      #3 reset = 1'b1;
      #1;
      chk("rst_score", 32'(score), 0);
      chk("rst_high_score", 32'(high_score), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_playing", 32'(playing), 0);
      chk("rst_new_record", 32'(new_record), 0);
      chk("rst_level_up", 32'(level_up), 0);
      model_clear();
      @(posedge clock_25);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 0;
      do_reset();

      // 1: start and three single-cycle food pulses
      step(1'b1, 1'b0, 1'b0, 1'b0);
      eat_n(3);
      chk("t1_score", 32'(score), 3);
      chk("t1_level", 32'(level), 0);
      chk("t1_playing", 32'(playing), 1);

      // 2: held food counts once, a fresh edge counts again
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_held", 32'(score), 4);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      eat_n(1);
      chk("t2_second_edge", 32'(score), 5);

      // 3: start+sync_reset -> IDLE; then level progression and saturation
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t3_sync_start_idle", 32'(playing), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      lu_count = 0;
      eat_n(9);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_tenth_score", 32'(score), 10);
      chk("t3_tenth_level", 32'(level), 1);
      chk("t3_tenth_pulse", 32'(level_up), 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_pulse_one_cycle", 32'(level_up), 0);
      eat_n(89);
      chk("t3_score_99", 32'(score), 99);
      chk("t3_level_9", 32'(level), 9);
      eat_n(2);
      chk("t3_sat_score", 32'(score), 99);
      chk("t3_sat_level", 32'(level), 9);
      chk("t3_pulse_count", 32'(lu_count), 9);

      // 4: high score across three games
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      eat_n(12);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_g1_hs", 32'(high_score), 12);
      chk("t4_g1_nr", 32'(new_record), 1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      eat_n(7);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_g2_hs", 32'(high_score), 12);
      chk("t4_g2_nr", 32'(new_record), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      eat_n(12);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_g3_score", 32'(score), 13);
      chk("t4_g3_hs", 32'(high_score), 13);
      chk("t4_g3_nr", 32'(new_record), 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // 6: stray events in OVER, start in PLAY
      eat_n(2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_over_score", 32'(score), 13);
      chk("t6_over_playing", 32'(playing), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      eat_n(3);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6_start_in_play", 32'(score), 3);
      chk("t6_still_playing", 32'(playing), 1);

      // 5: sync_reset mid-play keeps high score; full reset clears it
      eat_n(22);
      chk("t5_score_25", 32'(score), 25);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_sync_score", 32'(score), 0);
      chk("t5_sync_idle", 32'(playing), 0);
      chk("t5_sync_hs", 32'(high_score), 13);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_idle_ignores", 32'(score), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      eat_n(4);
      do_reset();
      chk("t5_reset_hs", 32'(high_score), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety bound against a stalled run.
   initial begin
      #4000000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
